// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
// Holds the FSM state type, the supported major opcodes, the ALU
// operation codes driven on alu_ctrl and the write-back source codes
// driven on result_src.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_ALU = 4'd2,
    S_EXEC_BR  = 4'd3,
    S_EXEC_JAL = 4'd4,
    S_MEM_RD   = 4'd5,
    S_LOAD_WB  = 4'd6,
    S_MEM_WR   = 4'd7,
    S_TRAP     = 4'd8
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the controller and memory.
//   mem_req   : request, held until mem_ready
//   mem_we    : request is a store (valid only with mem_req)
//   addr_src  : address source, 0 = PC, 1 = ALU result
//   mem_ready : memory completes the current request this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_src, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_src, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU-operation decoder.
//   funct3, funct7b5 : instruction fields
//   is_rtype         : instruction is register-register (enables SUB)
//   alu_ctrl         : ALU operation code
//   unsupported      : funct3 has no supported ALU operation (011)
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_ctrl,
  output logic       unsupported
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    unsupported = 1'b0;
    case (funct3)
      3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_ctrl = ALU_AND;
      3'b110:  alu_ctrl = ALU_OR;
      3'b100:  alu_ctrl = ALU_XOR;
      3'b010:  alu_ctrl = ALU_SLT;
      3'b001:  alu_ctrl = ALU_SLL;
      3'b101:  alu_ctrl = ALU_SRL;
      default: unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I core.
// Steps each instruction through fetch / decode / execute / memory states
// over a single shared memory port.
//   clk, rst           : clock, synchronous active-high reset
//   opcode, funct3,
//   funct7b5, EQ       : IR fields and ALU zero flag
//   mem                : memory handshake (master side)
//   ir_we, pc_we,
//   PCsrc, we, alu_src,
//   alu_ctrl,
//   result_src         : datapath controls
//   instr_done         : pulse on each retiring instruction
//   illegal            : sticky trap flag, cleared only by rst
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               EQ,
  multicycle_ctrl_if.master  mem,
  output logic               ir_we,
  output logic               pc_we,
  output logic               PCsrc,
  output logic               we,
  output logic               alu_src,
  output logic [2:0]         alu_ctrl,
  output logic [1:0]         result_src,
  output logic               instr_done,
  output logic               illegal
);

  state_t     state_reg;
  logic [2:0] dec_alu_ctrl;
  logic       dec_unsupported;

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (opcode == OP_R),
    .alu_ctrl    (dec_alu_ctrl),
    .unsupported (dec_unsupported)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:   if (mem.mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R, OP_I: state_reg <= dec_unsupported ? S_TRAP : S_EXEC_ALU;
            OP_LOAD:    state_reg <= S_MEM_RD;
            OP_STORE:   state_reg <= S_MEM_WR;
            OP_BRANCH:  state_reg <= (funct3 == 3'b000 || funct3 == 3'b001) ? S_EXEC_BR : S_TRAP;
            OP_JAL:     state_reg <= S_EXEC_JAL;
            default:    state_reg <= S_TRAP;
          endcase
        end
        S_EXEC_ALU, S_EXEC_BR, S_EXEC_JAL, S_LOAD_WB: state_reg <= S_FETCH;
        S_MEM_RD:  if (mem.mem_ready) state_reg <= S_LOAD_WB;
        S_MEM_WR:  if (mem.mem_ready) state_reg <= S_FETCH;
        S_TRAP:    state_reg <= S_TRAP;
        default:   state_reg <= S_TRAP;
      endcase
    end
  end

  // Outputs decode the registered state; rst forces everything low so an
  // abandoned request or pending strobe never leaks into the reset cycle.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_src = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    PCsrc        = 1'b0;
    we           = 1'b0;
    alu_src      = 1'b0;
    alu_ctrl     = ALU_ADD;
    result_src   = RES_ALU;
    illegal      = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          ir_we       = mem.mem_ready;
        end
        S_EXEC_ALU: begin
          alu_src  = (opcode == OP_I);
          alu_ctrl = dec_alu_ctrl;
          we       = 1'b1;
          pc_we    = 1'b1;
        end
        S_EXEC_BR: begin
          alu_ctrl = ALU_SUB;
          pc_we    = 1'b1;
          PCsrc    = (funct3 == 3'b000) ? EQ : !EQ;
        end
        S_EXEC_JAL: begin
          we         = 1'b1;
          result_src = RES_PC4;
          pc_we      = 1'b1;
          PCsrc      = 1'b1;
        end
        S_MEM_RD: begin
          mem.mem_req  = 1'b1;
          mem.addr_src = 1'b1;
          alu_src      = 1'b1;
          alu_ctrl     = ALU_ADD;
        end
        S_LOAD_WB: begin
          we         = 1'b1;
          result_src = RES_MEM;
          pc_we      = 1'b1;
        end
        S_MEM_WR: begin
          mem.mem_req  = 1'b1;
          mem.mem_we   = 1'b1;
          mem.addr_src = 1'b1;
          alu_src      = 1'b1;
          alu_ctrl     = ALU_ADD;
          pc_we        = mem.mem_ready;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_done = pc_we;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected
// retirement record of each instruction, a monitor pops and compares on
// every instr_done pulse.
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] J_OP  = 7'b1101111;

  typedef struct {
    int         cycles;
    logic       we;
    logic       pcsrc;
    logic       mem_we;
    logic       chk_res;
    logic [1:0] res;
    logic       chk_alu;
    logic       alu_src;
    logic [2:0] alu;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       EQ;
  logic       ir_we, pc_we, PCsrc, we, alu_src, instr_done, illegal;
  logic [2:0] alu_ctrl;
  logic [1:0] result_src;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  multicycle_ctrl_if mif ();

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .EQ         (EQ),
    .mem        (mif.master),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .PCsrc      (PCsrc),
    .we         (we),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .result_src (result_src),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: ALU operation implied by funct3 / funct7b5 for an ALU instruction.
  function automatic logic [2:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == R_OP && f7) ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b010:  return 3'd5;
      3'b001:  return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Reference: retirement record (CPI and controls in the retiring cycle).
  function automatic exp_t ref_model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic eq, input int fw, input int mw);
    exp_t e;
    e = '{cycles: fw + 2, we: 1'b0, pcsrc: 1'b0, mem_we: 1'b0, chk_res: 1'b0, res: 2'b00,
          chk_alu: 1'b0, alu_src: 1'b0, alu: 3'd0};
    if (op == R_OP || op == I_OP) begin
      e.cycles += 1; e.we = 1'b1; e.chk_res = 1'b1; e.res = 2'b00;
      e.chk_alu = 1'b1; e.alu_src = (op == I_OP); e.alu = ref_alu(op, f3, f7);
    end else if (op == BR_OP) begin
      e.cycles += 1; e.pcsrc = (f3 == 3'b000) ? eq : !eq;
      e.chk_alu = 1'b1; e.alu = 3'd1;
    end else if (op == J_OP) begin
      e.cycles += 1; e.we = 1'b1; e.pcsrc = 1'b1; e.chk_res = 1'b1; e.res = 2'b10;
    end else if (op == LD_OP) begin
      e.cycles += mw + 2; e.we = 1'b1; e.chk_res = 1'b1; e.res = 2'b01;
    end else begin
      e.cycles += mw + 1; e.mem_we = 1'b1;
      e.chk_alu = 1'b1; e.alu_src = 1'b1; e.alu = 3'd0;
    end
    return e;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    mif.mem_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one instruction: fetch waits fw cycles, data access waits mw cycles,
  // mem_ready is random whenever no request can be outstanding.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic eq, input int fw, input int mw);
    exp_t e;
    bit   is_mem;
    e = ref_model(op, f3, f7, eq, fw, mw);
    exp_q.push_back(e);
    is_mem = (op == LD_OP || op == ST_OP);
    opcode = op; funct3 = f3; funct7b5 = f7; EQ = eq;
    for (int c = 0; c < e.cycles; c++) begin
      if (c < fw)                                     mif.mem_ready = 1'b0;
      else if (c == fw)                               mif.mem_ready = 1'b1;
      else if (is_mem && c >= fw + 2 && c <= fw + 2 + mw) mif.mem_ready = (c == fw + 2 + mw);
      else                                            mif.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: scoreboard pops plus handshake protocol checks.
  initial begin : monitor
    int   cnt;
    logic p_req, p_rdy, p_mwe, p_as, p_rst;
    exp_t e;
    cnt = 0; p_req = 0; p_rdy = 0; p_mwe = 0; p_as = 0; p_rst = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        if (mif.mem_req || we || pc_we || ir_we || instr_done || illegal || mif.mem_we)
          check("rst_outputs_low", {mif.mem_req, mif.mem_we, we, pc_we, ir_we, instr_done, illegal}, 0);
      end else begin
        cnt++;
        if (!p_rst && p_req && !p_rdy)
          check("req_stable", {mif.mem_req, mif.mem_we, mif.addr_src}, {p_req, p_mwe, p_as});
        if (pc_we || instr_done) check("done_with_pcwe", instr_done, pc_we);
        if (ir_we) check("ir_we_qual", {mif.mem_req, mif.mem_ready, mif.addr_src}, 3'b110);
        if (instr_done) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_retire: got instr_done expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("cpi", cnt, e.cycles);
            check("we", we, e.we);
            check("pcsrc", PCsrc, e.pcsrc);
            check("mem_we", mif.mem_we, e.mem_we);
            if (e.chk_res) check("result_src", result_src, e.res);
            if (e.chk_alu) check("alu", {alu_src, alu_ctrl}, {e.alu_src, e.alu});
          end
          cnt = 0;
        end
      end
      p_req = mif.mem_req; p_rdy = mif.mem_ready; p_mwe = mif.mem_we;
      p_as = mif.addr_src; p_rst = rst;
    end
  end

  initial begin : stimulus
    logic [6:0] ops[6];
    logic [2:0] f3;
    logic [6:0] op;
    logic       ok;
    ops[0] = R_OP; ops[1] = I_OP; ops[2] = LD_OP; ops[3] = ST_OP; ops[4] = BR_OP; ops[5] = J_OP;
    opcode = R_OP; funct3 = 3'b000; funct7b5 = 1'b0; EQ = 1'b0; mif.mem_ready = 1'b0;

    // Reset: all outputs low while rst is high.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {mif.mem_req, mif.mem_we, mif.addr_src, ir_we, pc_we, PCsrc, we,
                          alu_src, alu_ctrl, result_src, instr_done, illegal}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset, then ADD (SUB form) with zero-wait memory.
    opcode = R_OP; funct3 = 3'b000; funct7b5 = 1'b1; EQ = 1'b0; mif.mem_ready = 1'b1;
    exp_q.push_back(ref_model(R_OP, 3'b000, 1'b1, 1'b0, 0, 0));
    @(negedge clk);
    check("add_fetch", {mif.mem_req, mif.addr_src, ir_we, pc_we}, 4'b1010);
    @(negedge clk);
    check("add_decode", {mif.mem_req, ir_we, we, pc_we}, 4'b0000);
    @(negedge clk);
    check("add_exec", {alu_ctrl, we, pc_we, PCsrc, alu_src}, {3'b001, 4'b1100});
    @(posedge clk);
    #1;

    // Load with two wait states, branches, JAL.
    run_instr(LD_OP, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(BR_OP, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(BR_OP, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr(J_OP,  3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(ST_OP, 3'b010, 1'b0, 1'b0, 1, 1);

    // Randomized legal instruction stream with random wait states.
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 5)];
      ok = 1'b0;
      f3 = 3'b000;
      while (!ok) begin
        f3 = 3'($urandom_range(0, 7));
        if (op == BR_OP)                    ok = (f3 == 3'b000 || f3 == 3'b001);
        else if (op == R_OP || op == I_OP)  ok = (f3 != 3'b011);
        else                                ok = 1'b1;
      end
      run_instr(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Illegal opcode: sticky trap with everything quiet for 10 cycles.
    opcode = 7'b1110011; funct3 = 3'b000; mif.mem_ready = 1'b1;
    @(posedge clk); #1 mif.mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      mif.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("trap_hold", {illegal, mif.mem_req, mif.mem_we, we, pc_we, ir_we, instr_done}, 7'b1000000);
      @(posedge clk); #1;
    end
    rst = 1'b1; mif.mem_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("trap_cleared", {illegal, mif.mem_req, mif.addr_src}, 3'b010);
    do_reset(1);

    // Unsupported funct3 traps: ALU 011 and branch 010.
    opcode = R_OP; funct3 = 3'b011; mif.mem_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    @(negedge clk);
    check("trap_alu_f3", {illegal, we, pc_we}, 3'b100);
    do_reset(1);
    opcode = BR_OP; funct3 = 3'b010; mif.mem_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    @(negedge clk);
    check("trap_br_f3", {illegal, we, pc_we}, 3'b100);
    do_reset(1);

    // Reset while a store waits in MEM_WR.
    opcode = ST_OP; funct3 = 3'b010; mif.mem_ready = 1'b1;
    @(posedge clk); #1 mif.mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1 mif.mem_ready = 1'b0;
    @(negedge clk);
    check("store_wait", {mif.mem_req, mif.mem_we, mif.addr_src, pc_we}, 4'b1110);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_store", {mif.mem_req, mif.mem_we, pc_we, we, ir_we}, 5'b00000);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("fetch_after_rst", {mif.mem_req, mif.addr_src, mif.mem_we, illegal}, 4'b1000);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
